reset_sequencer: RTL and testbench

//  Parametrised power-on/lock reset controller for the SoC top level. Synchronises an async
//  PLL-lock input and requires a run of consecutive locked cycles before release. Releases

---
 rtl/reset_seq_pkg.sv | 32 +++
 rtl/sync_chain.sv | 46 ++++
 rtl/reset_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq_pkg
//  Description : Shared types and helpers for the reset sequencer.
//                state_t - sequencer FSM states
//                cause_t - encoding of the last reset cause
//                cnt_width() - width of a counter holding a given number of
//                              distinct values (never below 1 bit)
//  Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_POR  = 2'd0,
      CAUSE_LOCK = 2'd1,
      CAUSE_SOFT = 2'd2
   } cause_t;

   // Width needed for a counter that takes 'values' distinct values (0..values-1).
   function automatic int unsigned cnt_width(input int unsigned values);
      return (values <= 2) ? 1 : $clog2(values);
   endfunction

endpackage : reset_seq_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_chain
//  Description : N-flop synchroniser for a single asynchronous level signal.
//                All flops clear to 0 on the synchronous reset.
//  Ports       : clk      in  capture clock
//                reset    in  synchronous active-high reset
//                d_async  in  asynchronous input level
//                q_sync   out input delayed by STAGES flops
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d_async,
   output logic q_sync
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   // Bit 0 captures the async input; each further bit shifts one stage on.
   if (STAGES > 1) begin : g_multi
      always_comb begin
         chain_d = {chain_q[STAGES-2:0], d_async};
      end
   end else begin : g_single
      always_comb begin
         chain_d = d_async;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q_sync = chain_q[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Power-on / PLL-lock reset controller. Synchronises the PLL
//                lock, requires HOLD_CYCLES consecutive locked cycles, then
//                releases CHANNELS reset domains STAGGER_CYCLES apart
//                (rst_out[0] first). Re-sequences on lock loss or a soft
//                reset request.
//  Macro       : RESET_SEQ_CAUSE_EN - adds the cause / lock_loss_count ports
//  Ports       : clk             in  PLL output clock
//                reset           in  synchronous active-high, full re-sequence
//                locked_async    in  PLL lock, asynchronous to clk
//                soft_reset_req  in  single-cycle re-sequence request
//                rst_out         out active-high domain resets (registered)
//                ready           out every channel released
//                cause           out last reset cause       (macro only)
//                lock_loss_count out saturating lock-losses  (macro only)
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned CHANNELS       = 4,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned HOLD_CYCLES    = 15,
   parameter int unsigned STAGGER_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                locked_async,
   input  logic                soft_reset_req,
   output logic [CHANNELS-1:0] rst_out,
   output logic                ready
`ifdef RESET_SEQ_CAUSE_EN
   ,
   output logic [1:0]          cause,
   output logic [7:0]          lock_loss_count
`endif
);

   // Number of cycles from the first to the last channel release.
   localparam int unsigned c_rel_span = (CHANNELS - 1) * STAGGER_CYCLES;
   localparam int unsigned c_hold_w   = cnt_width(HOLD_CYCLES);
   localparam int unsigned c_stag_w   = cnt_width(c_rel_span + 1);
   localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
   localparam logic [c_stag_w-1:0] c_stag_last = c_stag_w'(c_rel_span);

   logic                locked_s;
   state_t              state_q, state_d;
   logic [c_hold_w-1:0] hold_q, hold_d;
   logic [c_stag_w-1:0] stag_q, stag_d;
   logic [CHANNELS-1:0] rst_out_q, rst_out_d;
   logic                ready_q, ready_d;
   logic                rel_step;
   logic [c_stag_w-1:0] rel_pos;

   sync_chain #(
      .STAGES  (SYNC_STAGES)
   ) u_lock_sync (
      .clk     (clk),
      .reset   (reset),
      .d_async (locked_async),
      .q_sync  (locked_s)
   );

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      stag_d    = stag_q;
      rst_out_d = rst_out_q;
      ready_d   = ready_q;
      rel_step  = 1'b0;
      rel_pos   = '0;

      case (state_q)
         WAIT_LOCK: begin
            if (locked_s) begin
               state_d = HOLD;
            end
         end

         HOLD: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               hold_d  = '0;
            end else if (soft_reset_req) begin
               hold_d  = '0;
            end else if (hold_q == c_hold_last) begin
               // Entering RELEASE: position 0 releases channel 0 on this edge.
               hold_d   = '0;
               rel_step = 1'b1;
               rel_pos  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end

         RELEASE, RUN: begin
            if (!locked_s) begin
               state_d   = WAIT_LOCK;
               stag_d    = '0;
               rst_out_d = '1;
               ready_d   = 1'b0;
            end else if (soft_reset_req) begin
               state_d   = HOLD;
               hold_d    = '0;
               stag_d    = '0;
               rst_out_d = '1;
               ready_d   = 1'b0;
            end else if (state_q == RELEASE) begin
               rel_step = 1'b1;
               rel_pos  = stag_q + 1'b1;
            end
         end

         default: begin
            state_d = WAIT_LOCK;
         end
      endcase

      // Channel k is released once the release position reaches k*STAGGER.
      // Starting from the current outputs keeps rst_out monotone.
      if (rel_step) begin
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (32'(rel_pos) >= k * STAGGER_CYCLES) begin
               rst_out_d[k] = 1'b0;
            end
         end
         if (rel_pos == c_stag_last) begin
            state_d = RUN;
            stag_d  = '0;
            ready_d = 1'b1;
         end else begin
            state_d = RELEASE;
            stag_d  = rel_pos;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= WAIT_LOCK;
         hold_q    <= '0;
         stag_q    <= '0;
         rst_out_q <= '1;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         stag_q    <= stag_d;
         rst_out_q <= rst_out_d;
         ready_q   <= ready_d;
      end
   end

   assign rst_out = rst_out_q;
   assign ready   = ready_q;

`ifdef RESET_SEQ_CAUSE_EN
   localparam logic [7:0] c_loss_max = 8'd255;

   cause_t     cause_q, cause_d;
   logic [7:0] loss_cnt_q, loss_cnt_d;
   logic       lock_event;
   logic       soft_event;

   // Mirrors the FSM priority: lock loss wins over a soft request.
   always_comb begin
      lock_event = ~locked_s & ((state_q == RELEASE) | (state_q == RUN));
      soft_event = locked_s & soft_reset_req & (state_q != WAIT_LOCK);
      cause_d    = cause_q;
      loss_cnt_d = loss_cnt_q;
      if (lock_event) begin
         cause_d = CAUSE_LOCK;
         if (loss_cnt_q != c_loss_max) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
         end
      end else if (soft_event) begin
         cause_d = CAUSE_SOFT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cause_q    <= CAUSE_POR;
         loss_cnt_q <= '0;
      end else begin
         cause_q    <= cause_d;
         loss_cnt_q <= loss_cnt_d;
      end
   end

   assign cause           = cause_q;
   assign lock_loss_count = loss_cnt_q;
`endif

endmodule : reset_sequencer
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_sequencer
//  Description : Scoreboard bench. Two sequencers (STAGGER 4 and STAGGER 0)
//                share one stimulus stream; every expected output transition
//                is queued with its edge number and popped by a monitor each
//                time the outputs change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

   typedef struct packed {
      int unsigned e;
      logic [2:0]  rst;
      logic        rdy;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        locked_async = 1'b0;
   logic        soft_reset_req = 1'b0;
   logic [2:0]  rst_a, rst_b;
   logic        rdy_a, rdy_b;
   int unsigned edge_n = 0;
   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;
   logic        mon_en = 1'b0;
   ev_t         q_a[$];
   ev_t         q_b[$];
`ifdef RESET_SEQ_CAUSE_EN
   logic [1:0]  cause_a, cause_b;
   logic [7:0]  llc_a, llc_b;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   reset_sequencer #(
      .CHANNELS       (3),
      .SYNC_STAGES    (2),
      .HOLD_CYCLES    (8),
      .STAGGER_CYCLES (4)
   ) u_dut_a (
      .clk            (clk),
      .reset          (reset),
      .locked_async   (locked_async),
      .soft_reset_req (soft_reset_req),
      .rst_out        (rst_a),
      .ready          (rdy_a)
`ifdef RESET_SEQ_CAUSE_EN
      ,
      .cause          (cause_a),
      .lock_loss_count(llc_a)
`endif
   );

   reset_sequencer #(
      .CHANNELS       (3),
      .SYNC_STAGES    (2),
      .HOLD_CYCLES    (8),
      .STAGGER_CYCLES (0)
   ) u_dut_b (
      .clk            (clk),
      .reset          (reset),
      .locked_async   (locked_async),
      .soft_reset_req (soft_reset_req),
      .rst_out        (rst_b),
      .ready          (rdy_b)
`ifdef RESET_SEQ_CAUSE_EN
      ,
      .cause          (cause_b),
      .lock_loss_count(llc_b)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   function automatic ev_t mk(input int unsigned e, input logic [2:0] r, input logic d);
      ev_t v;
      v.e   = e;
      v.rst = r;
      v.rdy = d;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int unsigned n);
      while (edge_n < n) tick();
   endtask

   // Full release starting at edge e0 (first channel falls at e0).
   task automatic push_release(input int unsigned e0);
      q_a.push_back(mk(e0,      3'b110, 1'b0));
      q_a.push_back(mk(e0 + 4,  3'b100, 1'b0));
      q_a.push_back(mk(e0 + 8,  3'b000, 1'b1));
      q_b.push_back(mk(e0,      3'b000, 1'b1));
   endtask

   task automatic push_assert(input int unsigned e);
      q_a.push_back(mk(e, 3'b111, 1'b0));
      q_b.push_back(mk(e, 3'b111, 1'b0));
   endtask

   // Lock drops (seen by locked_s two edges later), then returns and fully releases.
   task automatic lose_and_relock();
      int unsigned l, e;
      locked_async = 1'b0;
      l = edge_n + 1;
      push_assert(l + 2);
      wait_until(l + 4);
      locked_async = 1'b1;
      e = edge_n + 1;
      push_release(e + 10);
      wait_until(e + 19);
   endtask

   // Monitor for the staggered instance.
   initial begin : mon_a
      logic [3:0] prev, cur;
      ev_t        ev;
      wait (mon_en);
      prev = {rst_a, rdy_a};
      forever begin
         @(posedge clk);
         #1;
         cur = {rst_a, rdy_a};
         if (cur !== prev) begin
            if (q_a.size() == 0) begin
               total_cnt++;
               $display("FAIL a_unexpected: got %b expected no change (edge %0d)", cur, edge_n);
            end else begin
               ev = q_a.pop_front();
               chk("a_edge", edge_n, ev.e);
               chk("a_out", {28'd0, cur}, {28'd0, ev.rst, ev.rdy});
            end
            prev = cur;
         end
      end
   end

   // Monitor for the zero-stagger instance.
   initial begin : mon_b
      logic [3:0] prev, cur;
      ev_t        ev;
      wait (mon_en);
      prev = {rst_b, rdy_b};
      forever begin
         @(posedge clk);
         #1;
         cur = {rst_b, rdy_b};
         if (cur !== prev) begin
            if (q_b.size() == 0) begin
               total_cnt++;
               $display("FAIL b_unexpected: got %b expected no change (edge %0d)", cur, edge_n);
            end else begin
               ev = q_b.pop_front();
               chk("b_edge", edge_n, ev.e);
               chk("b_out", {28'd0, cur}, {28'd0, ev.rst, ev.rdy});
            end
            prev = cur;
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      int unsigned e, l, s;

      // Reset state.
      repeat (2) tick();
      chk("reset_rst_a", rst_a, 3'b111);
      chk("reset_rdy_a", rdy_a, 1'b0);
      chk("reset_rst_b", rst_b, 3'b111);
      chk("reset_rdy_b", rdy_b, 1'b0);
`ifdef RESET_SEQ_CAUSE_EN
      chk("reset_cause", cause_a, 2'd0);
      chk("reset_llc", llc_a, 8'd0);
`endif
      reset  = 1'b0;
      mon_en = 1'b1;

      // Soft request while waiting for lock has no effect.
      soft_reset_req = 1'b1;
      tick();
      soft_reset_req = 1'b0;
      repeat (4) tick();

      // Power-up: channels fall at E+10/14/18.
      locked_async = 1'b1;
      e = edge_n + 1;
      push_release(e + 10);
      wait_until(e + 21);
`ifdef RESET_SEQ_CAUSE_EN
      chk("pwrup_cause", cause_a, 2'd0);
`endif

      // Lock loss in RUN, then relock with identical timing.
      lose_and_relock();
`ifdef RESET_SEQ_CAUSE_EN
      chk("lockloss_cause", cause_a, 2'd1);
      chk("lockloss_llc", llc_a, 8'd1);
`endif

      // Soft request in RUN: release at +8/+12/+16 with no sync delay.
      soft_reset_req = 1'b1;
      s = edge_n + 1;
      push_assert(s);
      push_release(s + 8);
      tick();
      soft_reset_req = 1'b0;
      wait_until(s + 20);
`ifdef RESET_SEQ_CAUSE_EN
      chk("soft_cause", cause_a, 2'd2);
`endif

      // Lock loss, then relock with a one-cycle glitch at E+5 restarting hold.
      locked_async = 1'b0;
      l = edge_n + 1;
      push_assert(l + 2);
      wait_until(l + 4);
      locked_async = 1'b1;
      e = edge_n + 1;
      push_release(e + 16);
      wait_until(e + 4);
      locked_async = 1'b0;
      tick();
      locked_async = 1'b1;
      wait_until(e + 27);
`ifdef RESET_SEQ_CAUSE_EN
      chk("glitch_llc", llc_a, 8'd2);
`endif

      // Soft request on the same edge locked_s falls: lock loss wins.
      locked_async = 1'b0;
      l = edge_n + 1;
      push_assert(l + 2);
      wait_until(l + 1);
      soft_reset_req = 1'b1;
      tick();
      soft_reset_req = 1'b0;
      wait_until(l + 5);
`ifdef RESET_SEQ_CAUSE_EN
      chk("simul_cause", cause_a, 2'd1);
      chk("simul_llc", llc_a, 8'd3);
`endif
      locked_async = 1'b1;
      e = edge_n + 1;
      push_release(e + 10);
      wait_until(e + 21);

      // Reset mid-RELEASE (after channel 0, before channel 1).
      locked_async = 1'b0;
      l = edge_n + 1;
      push_assert(l + 2);
      wait_until(l + 4);
      locked_async = 1'b1;
      e = edge_n + 1;
      q_a.push_back(mk(e + 10, 3'b110, 1'b0));
      q_b.push_back(mk(e + 10, 3'b000, 1'b1));
      push_assert(e + 12);
      push_release(e + 23);
      wait_until(e + 11);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wait_until(e + 34);
`ifdef RESET_SEQ_CAUSE_EN
      chk("midrel_cause", cause_a, 2'd0);
      chk("midrel_llc", llc_a, 8'd0);

      // 256 lock losses saturate the counter at 255.
      for (int i = 0; i < 256; i++) begin
         lose_and_relock();
      end
      chk("sat_llc", llc_a, 8'd255);
      chk("sat_cause", cause_a, 2'd1);
`endif

      repeat (5) tick();
      chk("a_pending", q_a.size(), 0);
      chk("b_pending", q_b.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_reset_sequencer
`default_nettype wire
